bt_uart_rx: RTL and testbench
=============================

# bt_uart_rx

Serial receiver for the Bluetooth module's TX line, feeding received command bytes into the audio controller. It synchronizes the asynchronous serial input, detects and qualifies start bits, samples 8N1 frames at mid-bit, and presents each good byte with a one-cycle strobe. Frames with a bad stop bit are reported on an error strobe and never delivered. The audio controller consumes `o_data`/`o_valid` as its command stream.

## Interface

Parameters:
- `CLK_HZ`, default 100_000_000. System clock frequency in Hz.
- `BAUD`, default 9600. Serial bit rate.
- `CLKS_PER_BIT`, derived as CLK_HZ/BAUD with truncating integer division. Must be ≥ 4; elaboration fails otherwise.

Ports:
- `i_clk`, input, 1. System clock; all state is on the rising edge.
- `i_rst_n`, input, 1. Asynchronous, active-low reset.
- `i_data`, input, 1. Raw serial line, idle high, asynchronous to `i_clk`.
- `o_data`, output, 8. Last good byte, LSB received first. Holds its value until the next good frame.
- `o_valid`, output, 1. One-cycle pulse; `o_data` is new in the same cycle.
- `o_frame_err`, output, 1. One-cycle pulse on a stop-bit failure.

## Operation

- **Input sync:** `i_data` passes through 2 flops, both resetting to 1. All logic uses the synchronized line `rx_s`.
- **States:** IDLE, START, DATA, STOP, BREAK.
- **IDLE:** clear the bit counter. If `rx_s` = 0, go to START and clear the clock counter.
- **START:** count to CLKS_PER_BIT/2 − 1, then sample.
  - `rx_s` = 0: go to DATA, clear the clock counter.
  - `rx_s` = 1: treat as a glitch and return to IDLE. No strobe.
- **DATA:** count to CLKS_PER_BIT − 1, then sample `rx_s` into shift register bit `bit_idx`.
  - Bit order is LSB first, `bit_idx` 0..7.
  - After bit 7, go to STOP.
- **STOP:** count to CLKS_PER_BIT − 1, then sample.
  - `rx_s` = 1: load `o_data` from the shift register, pulse `o_valid`, go to IDLE.
  - `rx_s` = 0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
- **BREAK:** stay until `rx_s` = 1, then go to IDLE. This prevents a held-low line from retriggering frames.
- **Counter width:** clock counter is $clog2(CLKS_PER_BIT) bits; bit index is 3 bits. Counters must not wrap inside a state.
- **Back-to-back frames:** a start bit arriving immediately after a stop sample must be accepted. IDLE re-arms in the cycle after STOP.
- **Strobes:** `o_valid` and `o_frame_err` are never high together and never high for more than one cycle.

## Timing

- **Reset values:** `o_data` = 8'h00, `o_valid` = 0, `o_frame_err` = 0, state IDLE, sync flops 1.
- **Reset mid-frame:** asserting `i_rst_n` during a frame abandons it with no strobe. After release, the block waits for a fresh falling edge.
- **Latency:** let T0 be the first `i_clk` edge that samples raw `i_data` low. `o_valid` or `o_frame_err` rises at T0 + 2 (sync) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles. The bench accepts ±1 cycle.
- **Glitch rejection:** a low pulse shorter than CLKS_PER_BIT/2 − 2 cycles is rejected.
- **Baud tolerance:** frames are received correctly with transmitter baud error up to ±3%.
- **Output registering:** `o_data` changes only on the `o_valid` cycle and is registered. Downstream may sample `o_data` on `o_valid` or at any later time.

## Structure

- **Shared package `uart_pkg`:**
  - `uart_state_t` enum (IDLE, START, DATA, STOP, BREAK).
  - Localparams for frame format: DATA_BITS = 8, STOP_BITS = 1.
  - The 8-bit command codes consumed by the audio controller (e.g. CMD_PLAY = 8'h01).
- **Sub-module `sync_2ff`:** the reusable 2-flop synchronizer. It has a reset-value parameter, set to 1 here.
- **Inline logic:** FSM, counters, and shift register live in `bt_uart_rx`.

## Test plan

Bench parameters: CLK_HZ = 1_600_000, BAUD = 100_000 (CLKS_PER_BIT = 16). Include one smoke run at the defaults.

- **Single byte:** send 0x01 → one `o_valid` pulse, `o_data` = 0x01 at T0 + 155 ±1, no `o_frame_err`.
- **Back-to-back:** send 0xA5 then 0x3C with zero idle between frames → two `o_valid` pulses 160 cycles apart, `o_data` = 0xA5 then 0x3C.
- **Glitch:** low pulse of 5 cycles on an idle line → no strobe, state returns to IDLE, next 0x7E is received correctly.
- **Framing error:** send 0x55 with a low stop bit, holding the line low 40 further cycles → one `o_frame_err` pulse, no `o_valid`, `o_data` keeps its prior value (0x3C). A following 0x01 after the line returns high is received.
- **Reset mid-frame:** assert `i_rst_n` = 0 during bit 4 of 0xFF → `o_data` = 0x00 and no strobes. After release, a full frame 0x81 yields `o_data` = 0x81.
- **Baud skew:** send 0xC3 at BAUD ×1.03 and ×0.97 → `o_data` = 0xC3 with `o_valid` each time.

Source files
------------

// File: rtl/bt_uart_rx_pkg.sv
// Shared definitions for the Bluetooth command UART: receiver states,
// frame format and the command byte codes the audio controller understands.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    localparam logic [7:0] CMD_PLAY   = 8'h01;
    localparam logic [7:0] CMD_PAUSE  = 8'h02;
    localparam logic [7:0] CMD_STOP   = 8'h03;
    localparam logic [7:0] CMD_NEXT   = 8'h04;
    localparam logic [7:0] CMD_PREV   = 8'h05;
    localparam logic [7:0] CMD_VOL_UP = 8'h10;
    localparam logic [7:0] CMD_VOL_DN = 8'h11;

endpackage

// File: rtl/bt_uart_rx_if.sv
// Received-byte stream from the UART receiver to the audio controller.
interface bt_uart_rx_if;

    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;

    modport master (output o_data, o_valid, o_frame_err);
    modport slave  (input  o_data, o_valid, o_frame_err);

endinterface

// File: rtl/bt_uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a
// selectable reset value so an idle-high line does not look active.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bt_uart_rx.sv
// 8N1 serial receiver: synchronizes the Bluetooth TX line, qualifies the
// start bit at half-bit, samples data mid-bit and strobes good bytes out.
module bt_uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_data,
    bt_uart_rx_if.master  rx
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST  = 3'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_ratio
            $error("bt_uart_rx: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic             rx_s;
    uart_state_t      state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .d     (i_data),
        .q     (rx_s)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            clk_cnt        <= '0;
            bit_idx        <= '0;
            shreg          <= '0;
            rx.o_data      <= '0;
            rx.o_valid     <= 1'b0;
            rx.o_frame_err <= 1'b0;
        end else begin
            rx.o_valid     <= 1'b0;
            rx.o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    clk_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                // Half-bit check: a line that is back high by now was a glitch.
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt        <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == BIT_LAST) state <= STOP;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            rx.o_data  <= shreg;
                            rx.o_valid <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            rx.o_frame_err <= 1'b1;
                            state          <= BREAK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // A line held low after a bad stop bit must not start new frames.
                BREAK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bt_uart_rx.sv
// Bench for bt_uart_rx: directed and random 8N1 frames against a queue of
// expected receive events derived from the frame contents and bit timing.
module tb_bt_uart_rx;
    import uart_pkg::*;

    localparam int CLK_T = 100;
    localparam int BIT_T = 16 * CLK_T;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
        bit         lat;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic line  = 1'b1;
    logic line_d = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int dflt_cnt    = 0;
    logic prev_strobe = 1'b0;
    logic [7:0] last_good = 8'h00;

    ev_t exp_q[$];
    ev_t obs_q[$];

    always #(CLK_T / 2) clk = ~clk;

    bt_uart_rx_if rx_if ();
    bt_uart_rx_if dflt_if ();

    bt_uart_rx #(.CLK_HZ(1_600_000), .BAUD(100_000)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (line),
        .rx      (rx_if)
    );

    bt_uart_rx u_dflt (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (line_d),
        .rx      (dflt_if)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && (rx_if.o_valid || rx_if.o_frame_err)) begin
            chk("strobe_excl", {31'd0, rx_if.o_valid && rx_if.o_frame_err}, 0);
            chk("strobe_width", {31'd0, prev_strobe}, 0);
            obs_q.push_back('{rx_if.o_frame_err, rx_if.o_data, cyc, 1'b0});
        end
        prev_strobe = rx_if.o_valid || rx_if.o_frame_err;
        if (dflt_if.o_valid || dflt_if.o_frame_err) dflt_cnt++;
    end

    task automatic align();
        @(posedge clk);
        #10;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #10;
    endtask

    // Expected outcome is queued before the frame is driven: the first
    // sampling edge is the next posedge after the line falls.
    task automatic send_frame(input logic [7:0] b, input bit stop_hi, input int bit_t, input bit lat);
        ev_t e;
        e.cyc = cyc + 1;
        e.lat = lat;
        e.err = !stop_hi;
        if (stop_hi) last_good = b;
        e.data = last_good;
        exp_q.push_back(e);
        line = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            line = b[i];
            #(bit_t);
        end
        line = stop_hi;
        #(bit_t);
    endtask

    task automatic drain(input string tag);
        ev_t e;
        ev_t o;
        int  lat;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                chk({tag, "_missing"}, 0, 1);
            end else begin
                o = obs_q.pop_front();
                chk({tag, "_kind"}, {31'd0, o.err}, {31'd0, e.err});
                chk({tag, "_data"}, {24'd0, o.data}, {24'd0, e.data});
                if (e.lat) begin
                    lat = o.cyc - e.cyc;
                    chk({tag, "_lat"}, (lat >= 154 && lat <= 156) ? 155 : lat, 155);
                end
            end
        end
        chk({tag, "_extra"}, obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        #(5_000_000);
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b;
        bit         stop_hi;

        repeat (3) @(posedge clk);
        #10;
        chk("rst_data", {24'd0, rx_if.o_data}, 0);
        chk("rst_valid", {31'd0, rx_if.o_valid}, 0);
        chk("rst_ferr", {31'd0, rx_if.o_frame_err}, 0);
        chk("rst_state", u_dut.state, IDLE);
        chk("dflt_rst_data", {24'd0, dflt_if.o_data}, 0);
        rst_n = 1'b1;
        idle(5);

        // Default-rate instance sees a short low pulse it must reject.
        line_d = 1'b0;
        send_frame(CMD_PLAY, 1'b1, BIT_T, 1'b1);
        line_d = 1'b1;
        idle(20);
        drain("single");

        line = 1'b0;
        #(5 * CLK_T);
        line = 1'b1;
        idle(20);
        chk("glitch_state", u_dut.state, IDLE);
        drain("glitch");
        send_frame(8'h7E, 1'b1, BIT_T, 1'b1);
        idle(20);
        drain("after_glitch");

        send_frame(8'hA5, 1'b1, BIT_T, 1'b1);
        send_frame(8'h3C, 1'b1, BIT_T, 1'b1);
        idle(20);
        if (obs_q.size() == 2) chk("b2b_gap", obs_q[1].cyc - obs_q[0].cyc, 160);
        else                   chk("b2b_count", obs_q.size(), 2);
        drain("b2b");

        send_frame(8'h55, 1'b0, BIT_T, 1'b1);
        #(40 * CLK_T);
        chk("break_state", u_dut.state, BREAK);
        line = 1'b1;
        idle(20);
        drain("ferr");
        chk("ferr_hold", {24'd0, rx_if.o_data}, 8'h3C);
        send_frame(CMD_PLAY, 1'b1, BIT_T, 1'b1);
        idle(20);
        drain("after_ferr");

        line = 1'b0;
        #(BIT_T);
        line = 1'b1;
        #(4 * BIT_T + BIT_T / 2);
        rst_n = 1'b0;
        last_good = 8'h00;
        #(3 * CLK_T);
        rst_n = 1'b1;
        idle(200);
        chk("rst_mid_data", {24'd0, rx_if.o_data}, 0);
        chk("rst_mid_state", u_dut.state, IDLE);
        drain("rst_mid");
        send_frame(8'h81, 1'b1, BIT_T, 1'b1);
        idle(20);
        drain("after_rst");

        align();
        send_frame(8'hC3, 1'b1, 1553, 1'b0);
        idle(30);
        drain("skew_fast");
        send_frame(8'hC3, 1'b1, 1649, 1'b0);
        idle(30);
        drain("skew_slow");

        for (int n = 0; n < 20; n++) begin
            b       = 8'($urandom);
            stop_hi = ($urandom_range(0, 4) != 0);
            idle($urandom_range(0, 10));
            send_frame(b, stop_hi, BIT_T, 1'b1);
            if (!stop_hi) begin
                #($urandom_range(0, 30) * CLK_T);
                line = 1'b1;
                idle(3);
            end
        end
        idle(30);
        drain("random");

        chk("dflt_strobes", dflt_cnt, 0);
        chk("dflt_state", u_dflt.state, IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
